// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types, widths and byte-swap helper for the SHA-256 target checker
package sha256_pkg;

    localparam int unsigned digest_width_lp = 256;

    typedef enum logic [1:0] {
        eNoTgt  = 2'd0,
        eScan   = 2'd1,
        eReport = 2'd2
    } state_e;

    // Byte k of the digest moves to byte 31-k (byte 0 is the most significant byte).
    function automatic logic [digest_width_lp-1:0] swap_bytes(input logic [digest_width_lp-1:0] d);
        logic [digest_width_lp-1:0] r;
        r = '0;
        for (int k = 0; k < digest_width_lp / 8; k++) begin
            r[8*k +: 8] = d[digest_width_lp - 8 - 8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_target_check_if.sv
// rtl/sha256_target_check_if.sv - target load, digest input and hit result handshakes
interface sha256_target_check_if
    import sha256_pkg::*;
#(
    parameter int idx_width_p = 32
);
    logic                       tgt_v_i;
    logic [digest_width_lp-1:0] tgt_i;
    logic                       tgt_ready_o;
    logic                       v_i;
    logic [digest_width_lp-1:0] data_i;
    logic                       yumi_o;
    logic                       v_o;
    logic [digest_width_lp-1:0] data_o;
    logic [idx_width_p-1:0]     idx_o;
    logic [idx_width_p-1:0]     count_o;
    logic                       yumi_i;

    modport slave (
        input  tgt_v_i, tgt_i, v_i, data_i, yumi_i,
        output tgt_ready_o, yumi_o, v_o, data_o, idx_o, count_o
    );

    modport master (
        output tgt_v_i, tgt_i, v_i, data_i, yumi_i,
        input  tgt_ready_o, yumi_o, v_o, data_o, idx_o, count_o
    );
endinterface

// File: rtl/sha256_digest_lt.sv
// rtl/sha256_digest_lt.sv - optional byte swap followed by 256-bit unsigned less-than
module sha256_digest_lt
    import sha256_pkg::*;
#(
    parameter bit swap_bytes_p = 1'b1
) (
    input  logic [digest_width_lp-1:0] i_digest,
    input  logic [digest_width_lp-1:0] i_target,
    output logic                       o_lt
);
    logic [digest_width_lp-1:0] w_cmp;

    generate
        if (swap_bytes_p) begin : g_swap
            assign w_cmp = swap_bytes(i_digest);
        end else begin : g_noswap
            assign w_cmp = i_digest;
        end
    endgenerate

    assign o_lt = (w_cmp < i_target);

endmodule

// File: rtl/sha256_target_check.sv
// rtl/sha256_target_check.sv - scans a digest stream and reports the first digest below the target
module sha256_target_check
    import sha256_pkg::*;
#(
    parameter int idx_width_p  = 32,
    parameter bit swap_bytes_p = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    sha256_target_check_if.slave  bus
);
    state_e                     r_state;
    state_e                     w_next;
    logic [digest_width_lp-1:0] r_tgt;
    logic                       r_stage_v;
    logic [digest_width_lp-1:0] r_stage_data;
    logic [idx_width_p-1:0]     r_stage_idx;
    logic [idx_width_p-1:0]     r_count;
    logic [digest_width_lp-1:0] r_res_data;
    logic [idx_width_p-1:0]     r_res_idx;

    logic w_lt;
    logic w_hit;
    logic w_tgt_ready;
    logic w_yumi;
    logic w_v_o;
    logic w_load;

    sha256_digest_lt #(
        .swap_bytes_p (swap_bytes_p)
    ) u_lt (
        .i_digest (r_stage_data),
        .i_target (r_tgt),
        .o_lt     (w_lt)
    );

    assign w_hit  = r_stage_v & w_lt & (r_state == eScan);
    assign w_load = bus.tgt_v_i & w_tgt_ready;

    always_comb begin
        w_next      = r_state;
        w_tgt_ready = 1'b0;
        w_yumi      = 1'b0;
        w_v_o       = 1'b0;
        case (r_state)
            eNoTgt: begin
                w_tgt_ready = 1'b1;
                if (bus.tgt_v_i) w_next = eScan;
            end
            eScan: begin
                w_tgt_ready = 1'b1;
                w_yumi      = bus.v_i & ~bus.tgt_v_i & ~w_hit;
                // A target load discards the stage, so it outranks a pending hit.
                if (bus.tgt_v_i)  w_next = eScan;
                else if (w_hit)   w_next = eReport;
            end
            eReport: begin
                w_v_o = 1'b1;
                if (bus.yumi_i) w_next = eScan;
            end
            default: w_next = eNoTgt;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= eNoTgt;
            r_tgt        <= '0;
            r_stage_v    <= 1'b0;
            r_stage_data <= '0;
            r_stage_idx  <= '0;
            r_count      <= '0;
            r_res_data   <= '0;
            r_res_idx    <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_tgt     <= bus.tgt_i;
                r_count   <= '0;
                r_stage_v <= 1'b0;
            end else begin
                // The stage holds a digest for exactly one compare cycle.
                r_stage_v <= w_yumi;
                if (w_hit) begin
                    r_res_data <= r_stage_data;
                    r_res_idx  <= r_stage_idx;
                end
                if (w_yumi) begin
                    r_stage_data <= bus.data_i;
                    r_stage_idx  <= r_count;
                    r_count      <= r_count + 1'b1;
                end
            end
        end
    end

    assign bus.tgt_ready_o = w_tgt_ready;
    assign bus.yumi_o      = w_yumi;
    assign bus.v_o         = w_v_o;
    assign bus.data_o      = r_res_data;
    assign bus.idx_o       = r_res_idx;
    assign bus.count_o     = r_count;

endmodule

// File: tb/tb_sha256_target_check.sv
// tb/tb_sha256_target_check.sv - directed checks of the target checker in both swap modes and a narrow counter
module tb_sha256_target_check;
    logic clk;
    logic reset;
    int   n_run;
    int   n_fail;

    localparam logic [255:0] ONES = {256{1'b1}};
    localparam logic [255:0] PAT  = {8{32'h12345678}};

    sha256_target_check_if #(.idx_width_p(32)) a ();
    sha256_target_check_if #(.idx_width_p(32)) b ();
    sha256_target_check_if #(.idx_width_p(4))  c ();

    sha256_target_check #(.idx_width_p(32), .swap_bytes_p(1'b0)) dut_a (
        .clk_i (clk), .reset_i (reset), .bus (a)
    );
    sha256_target_check #(.idx_width_p(32), .swap_bytes_p(1'b1)) dut_b (
        .clk_i (clk), .reset_i (reset), .bus (b)
    );
    sha256_target_check #(.idx_width_p(4), .swap_bytes_p(1'b0)) dut_c (
        .clk_i (clk), .reset_i (reset), .bus (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_run = 0; n_fail = 0;
        a.tgt_v_i = 0; a.tgt_i = '0; a.v_i = 0; a.data_i = '0; a.yumi_i = 0;
        b.tgt_v_i = 0; b.tgt_i = '0; b.v_i = 0; b.data_i = '0; b.yumi_i = 0;
        c.tgt_v_i = 0; c.tgt_i = '0; c.v_i = 0; c.data_i = '0; c.yumi_i = 0;
        reset = 1;
        step(); step();
        reset = 0;

        chk("rst_v_o", a.v_o, 0);
        chk("rst_tgt_ready", a.tgt_ready_o, 1);
        chk("rst_count", a.count_o, 0);
        chk("rst_idx", a.idx_o, 0);
        chk("rst_data", a.data_o, 0);

        // digests offered with no target
        a.v_i = 1; a.data_i = 256'd1; #1;
        chk("notgt_yumi", a.yumi_o, 0);
        step();
        chk("notgt_v_o", a.v_o, 0);
        chk("notgt_ready", a.tgt_ready_o, 1);

        // basic hit, target 2^240
        a.v_i = 0; a.tgt_v_i = 1; a.tgt_i = 256'd1 << 240;
        step();
        a.tgt_v_i = 0;
        a.v_i = 1; a.data_i = 256'd1 << 250; #1;
        chk("basic_yumi0", a.yumi_o, 1);
        step();
        a.data_i = 256'd1 << 245; #1;
        chk("basic_yumi1", a.yumi_o, 1);
        step();
        a.data_i = 256'd1 << 239; #1;
        chk("basic_yumi2", a.yumi_o, 1);
        step();
        a.data_i = 256'd1 << 255; #1;
        chk("hitcycle_yumi", a.yumi_o, 0);
        chk("hitcycle_v_o", a.v_o, 0);
        step();
        chk("basic_v_o", a.v_o, 1);
        chk("basic_idx", a.idx_o, 2);
        chk("basic_count", a.count_o, 3);
        chk("basic_data", a.data_o, 256'd1 << 239);

        // hold with v_i and tgt_v_i asserted
        a.tgt_v_i = 1; a.tgt_i = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_yumi", a.yumi_o, 0);
            chk("hold_ready", a.tgt_ready_o, 0);
            chk("hold_v_o", a.v_o, 1);
            chk("hold_idx", a.idx_o, 2);
            chk("hold_data", a.data_o, 256'd1 << 239);
            step();
        end
        a.tgt_v_i = 0; a.yumi_i = 1; a.data_i = 256'd1 << 250; #1;
        chk("take_yumi", a.yumi_o, 0);
        step();
        a.yumi_i = 0; a.data_i = 256'd1 << 200; #1;
        chk("after_take_v_o", a.v_o, 0);
        chk("after_take_yumi", a.yumi_o, 1);
        step();
        a.v_i = 0; #1;
        chk("cont_cmp_v_o", a.v_o, 0);
        step();
        chk("cont_v_o", a.v_o, 1);
        chk("cont_idx", a.idx_o, 3);
        chk("cont_count", a.count_o, 4);
        chk("cont_data", a.data_o, 256'd1 << 200);
        a.yumi_i = 1; step(); a.yumi_i = 0;
        chk("cont_taken", a.v_o, 0);

        // equal digest does not hit
        a.tgt_v_i = 1; a.tgt_i = PAT; step(); a.tgt_v_i = 0;
        a.v_i = 1; a.data_i = PAT; #1;
        chk("eq_yumi", a.yumi_o, 1);
        step(); a.v_i = 0; step(); step();
        chk("eq_v_o", a.v_o, 0);
        chk("eq_count", a.count_o, 1);

        // target 0 never hits
        a.tgt_v_i = 1; a.tgt_i = '0; step(); a.tgt_v_i = 0;
        for (int i = 0; i < 8; i++) begin
            a.v_i = 1; a.data_i = {8{$urandom()}}; #1;
            chk("t0_yumi", a.yumi_o, 1);
            step();
        end
        a.v_i = 0; step(); step();
        chk("t0_v_o", a.v_o, 0);
        chk("t0_count", a.count_o, 8);

        // all-ones target: all-ones digest misses, zero digest hits
        a.tgt_v_i = 1; a.tgt_i = ONES; step(); a.tgt_v_i = 0;
        a.v_i = 1; a.data_i = ONES; step();
        a.data_i = '0; #1;
        chk("ones_yumi", a.yumi_o, 1);
        step();
        a.v_i = 0; #1;
        chk("ones_nohit", a.v_o, 0);
        step();
        chk("zero_hit", a.v_o, 1);
        chk("zero_idx", a.idx_o, 1);
        chk("zero_data", a.data_o, 0);
        a.yumi_i = 1; step(); a.yumi_i = 0;

        // reload with a hitting digest in the stage and v_i high
        a.v_i = 1; a.data_i = '0; step();
        a.tgt_v_i = 1; a.tgt_i = ONES; #1;
        chk("reload_yumi", a.yumi_o, 0);
        chk("reload_ready", a.tgt_ready_o, 1);
        step();
        a.tgt_v_i = 0; a.v_i = 0;
        chk("reload_count", a.count_o, 0);
        step();
        chk("reload_v_o0", a.v_o, 0);
        step();
        chk("reload_v_o1", a.v_o, 0);

        // reset during report
        a.v_i = 1; a.data_i = ONES; step();
        a.data_i = '0; step();
        a.v_i = 0; step();
        chk("prerst_v_o", a.v_o, 1);
        chk("prerst_idx", a.idx_o, 1);
        reset = 1; step(); reset = 0;
        chk("midrst_v_o", a.v_o, 0);
        chk("midrst_idx", a.idx_o, 0);
        chk("midrst_count", a.count_o, 0);
        chk("midrst_ready", a.tgt_ready_o, 1);

        // byte-swapped compare, target 2^8
        b.tgt_v_i = 1; b.tgt_i = 256'd256; step(); b.tgt_v_i = 0;
        b.v_i = 1; b.data_i = 256'd1; #1;
        chk("swap_yumi0", b.yumi_o, 1);
        step();
        b.data_i = 256'd1 << 248; #1;
        chk("swap_yumi1", b.yumi_o, 1);
        step();
        b.v_i = 0; #1;
        chk("swap_lsb_nohit", b.v_o, 0);
        step();
        chk("swap_msb_hit", b.v_o, 1);
        chk("swap_idx", b.idx_o, 1);
        chk("swap_data", b.data_o, 256'd1 << 248);

        // 4-bit counter wraps after 16
        c.tgt_v_i = 1; c.tgt_i = '0; step(); c.tgt_v_i = 0;
        for (int i = 0; i < 17; i++) begin
            c.v_i = 1; c.data_i = 256'(i + 1); step();
        end
        c.v_i = 0; step(); step();
        chk("wrap_count", c.count_o, 1);
        chk("wrap_v_o", c.v_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
